// File: rtl/mpu_int_ctrl.sv
// mpu_int_ctrl: fixed-priority interrupt gate between N_CH MPU cores and the
// main processor. Each channel latches a request plus payload, stalls its MPU
// (en=0) until the host commits it, and is dispatched lowest-index-first.
// Optional build macro: MPU_INT_TIMEOUT_EN (auto-release after TIMEOUT cycles).
module mpu_int_ctrl #(
   parameter int unsigned N_CH    = 4,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned TIMEOUT = 4,
   parameter int unsigned VEC_W   = 2
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic [N_CH-1:0]          irq,
   input  logic [N_CH*DATA_W-1:0]   data,
   input  logic [N_CH-1:0]          mask,
   output logic [N_CH-1:0]          en,
   output logic                     host_irq,
   output logic [VEC_W-1:0]         host_vec,
   output logic [DATA_W-1:0]        host_data,
   input  logic                     host_ack,
   output logic [N_CH-1:0]          ovf,
   input  logic                     ovf_clr,
   output logic                     timeout
);

   if (VEC_W != $clog2(N_CH) || N_CH < 2 || TIMEOUT < 1) begin : g_param_check
      $error("mpu_int_ctrl: invalid parameterisation");
   end

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SERVE = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [N_CH-1:0]     r_pend;
   logic [N_CH-1:0]     w_pend_nxt;
   logic [N_CH-1:0]     w_ld;
   logic [N_CH-1:0]     w_ovf_set;
   logic [N_CH-1:0]     w_disp;
   logic [N_CH-1:0]     r_en;
   logic [N_CH-1:0]     r_ovf;
   logic [DATA_W-1:0]   r_payload [N_CH];
   logic                r_host_irq;
   logic [VEC_W-1:0]    r_host_vec;
   logic [DATA_W-1:0]   r_host_data;
   logic                w_sel_vld;
   logic [VEC_W-1:0]    w_sel_idx;
   logic                w_expire;
   logic                w_release;

   assign w_disp    = r_pend & ~mask;
   assign en        = r_en;
   assign ovf       = r_ovf;
   assign host_irq  = r_host_irq;
   assign host_vec  = r_host_vec;
   assign host_data = r_host_data;

   // Lowest-index unmasked pending channel
   always_comb begin
      w_sel_vld = 1'b0;
      w_sel_idx = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (!w_sel_vld && w_disp[i]) begin
            w_sel_vld = 1'b1;
            w_sel_idx = VEC_W'(i);
         end
      end
   end

   // FSM next state; release covers both host ack and timeout expiry
   always_comb begin
      w_state_nxt = r_state;
      w_release   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_sel_vld) w_state_nxt = ST_SERVE;
         end
         ST_SERVE: begin
            if (host_ack || w_expire) begin
               w_release   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Per-channel pending/overflow decisions; a new irq on the channel being
   // released re-arms it instead of clearing it (and is not an overflow)
   always_comb begin
      w_pend_nxt = r_pend;
      w_ld       = '0;
      w_ovf_set  = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (irq[i]) begin
            if (!r_pend[i] || (w_release && r_host_vec == VEC_W'(i))) begin
               w_pend_nxt[i] = 1'b1;
               w_ld[i]       = 1'b1;
            end else begin
               w_ovf_set[i]  = 1'b1;
            end
         end else if (w_release && r_host_vec == VEC_W'(i)) begin
            w_pend_nxt[i] = 1'b0;
         end
      end
   end

   // FSM state register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Pending, enable, overflow and payload capture
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_pend <= '0;
         r_en   <= '1;
         r_ovf  <= '0;
         for (int unsigned i = 0; i < N_CH; i++) r_payload[i] <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         r_en   <= ~w_pend_nxt;
         r_ovf  <= (r_ovf & ~{N_CH{ovf_clr}}) | w_ovf_set;
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_ld[i]) r_payload[i] <= data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Host-side interrupt, vector and payload
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_host_irq  <= 1'b0;
         r_host_vec  <= '0;
         r_host_data <= '0;
      end else if (r_state == ST_IDLE && w_sel_vld) begin
         r_host_irq  <= 1'b1;
         r_host_vec  <= w_sel_idx;
         r_host_data <= r_payload[w_sel_idx];
      end else if (w_release) begin
         r_host_irq  <= 1'b0;
      end
   end

`ifdef MPU_INT_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;

   // Ack on the expiry edge takes precedence, so expiry requires no ack
   assign w_expire = (r_state == ST_SERVE) && !host_ack &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));
   assign timeout  = r_timeout;

   // Service-time counter; held at zero in IDLE so it starts fresh each SERVE
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
         if (r_state == ST_IDLE || w_release) r_cnt <= '0;
         else                                 r_cnt <= r_cnt + CNT_W'(1);
      end
   end
`else
   assign w_expire = 1'b0;
   assign timeout  = 1'b0;
`endif

endmodule

// File: doc/mpu_int_ctrl.md
Name: mpu_int_ctrl

Overview:
- Parametrised multi-channel interrupt gate between N_CH MPU cores and the main processor.
- Each MPU raises irq with a DATA_W payload; its enable drops until the main processor commits (acks) that interrupt.
- Fixed-priority arbiter (lowest index wins) serialises pending channels onto a single host interrupt line.
- Adds per-channel masking, sticky overflow and an optional auto-release timeout.

Parameters:
- N_CH, 4, number of MPU channels (>=2).
- DATA_W, 64, payload width per channel.
- TIMEOUT, 4, cycles in service before auto-release (used only with MPU_INT_TIMEOUT_EN; >=1).
- VEC_W, 2, channel index width; must equal clog2(N_CH).

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- irq  in  N_CH  per-channel interrupt request, sampled each rising edge
- data  in  N_CH*DATA_W  channel i payload in bits [i*DATA_W +: DATA_W]
- mask  in  N_CH  1 = channel not dispatched (still latches pending)
- en  out  N_CH  1 = MPU i may run
- host_irq  out  1  interrupt to main processor
- host_vec  out  VEC_W  index of channel in service
- host_data  out  DATA_W  payload of channel in service
- host_ack  in  1  single-cycle commit from main processor
- ovf  out  N_CH  sticky: irq arrived while channel already pending
- ovf_clr  in  1  clears all ovf bits
- timeout  out  1  one-cycle pulse on auto-release

Behaviour:
- One clock (sys_clk); reset is synchronous and active-high (sys_rst). Reset mid-operation aborts service immediately.
- Reset values: pending=0, payload regs=0, en=all 1, host_irq=0, host_vec=0, host_data=0, ovf=0, timeout=0, FSM=IDLE, counter=0.
- Latching: irq[i]=1 at edge k with pending[i]=0 sets pending[i] and captures data slice i. en[i]=0 from edge k. en[i] = ~pending[i], registered.
- irq[i]=1 while pending[i]=1: payload not overwritten; ovf[i] set.
- ovf_clr clears all ovf. Same-cycle set and clear on one bit: set wins.
- FSM IDLE:
  - If (pending & ~mask) is non-zero, select the lowest index j.
  - Load host_vec=j and host_data=payload[j]; go SERVE. host_irq=1 from that edge.
  - irq-to-host_irq latency is 2 edges.
- FSM SERVE:
  - host_irq held 1; host_vec/host_data stable.
  - host_ack=1 at edge m: clear pending[host_vec]; host_irq=0 and en[host_vec]=1 from edge m; go IDLE.
  - At least one idle cycle separates consecutive services.
- host_ack in IDLE: ignored.
- Mask changes during SERVE: no effect on the channel in service.
- Same edge as ack, irq on the channel in service: new irq wins. pending stays 1, new payload captured, en stays 0, no ovf. Channel is re-dispatched via IDLE.
- Irqs on other channels during SERVE: latch normally and are arbitrated after return to IDLE.
- Fully masked pending channels remain pending with en=0 indefinitely.

Optional Feature:
- Macro: MPU_INT_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to SERVE and increments each SERVE cycle without ack.
  - When the counter reaches TIMEOUT-1 with no ack, the next edge auto-releases exactly as an ack would, and timeout pulses 1 for one cycle.
  - Ack on the same edge as expiry counts as an ack; no timeout pulse.
- Undefined:
  - SERVE waits indefinitely for host_ack.
  - timeout tied 0; no counter logic present.

Test Plan:
- Reset then idle:
  - en=4'b1111, host_irq=0, ovf=0.
  - Assert sys_rst during SERVE: all outputs return to reset values on the next edge.
- irq[2]=1 for one cycle, data slice 2=64'hDEAD_BEEF at edge 0:
  - en[2]=0 after edge 0.
  - host_irq=1, host_vec=2, host_data=64'hDEAD_BEEF after edge 1.
  - host_ack at edge 5: host_irq=0 and en[2]=1 after edge 5.
- irq[3] and irq[1] in the same cycle:
  - Channel 1 serviced first; ack it.
  - After one IDLE cycle, channel 3 served with its own payload.
- Priority override under mask:
  - mask=4'b0010, irq[1] and irq[3]: channel 3 served.
  - Clear mask, ack 3: channel 1 served next.
- Overflow and re-dispatch:
  - irq[0] twice while pending: ovf[0]=1, host_data keeps the first payload.
  - ovf_clr: ovf=0.
  - irq[0] on the same edge as ack of 0: channel 0 re-dispatched with the new payload, ovf stays 0.
- With MPU_INT_TIMEOUT_EN, TIMEOUT=4, no ack:
  - host_irq high for exactly 4 cycles, then timeout pulse, en restored.
  - Without the macro: host_irq stays high for 100 cycles.
